pixel_fetch: RTL and testbench

//  Pixel read stage for the frame image held in byte-wide memory (3 bytes/pixel).

---
 rtl/pixel_pkg.sv | 20 ++
 rtl/pixel_addr_calc.sv | 43 ++++
 rtl/pixel_fetch.sv | 126 ++++++++++++
 tb/tb_pixel_fetch.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared types for the pixel fetch stage: pixel byte layout, RGB record and fetch FSM states.
package pixel_pkg;

  localparam int unsigned BYTES_PER_PIXEL = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    READ,
    DRAIN,
    OUT
  } fetch_state_t;

endpackage

// File: rtl/pixel_addr_calc.sv
// Registered (x,y) -> byte address of the pixel, plus the out-of-range flag.
// Range checking is built only when PIXEL_FETCH_BOUNDS_CHECK_EN is defined.
module pixel_addr_calc
  import pixel_pkg::*;
#(
  parameter int unsigned IMG_W     = 900,
  parameter int unsigned IMG_H     = 300,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [$clog2(IMG_W)-1:0] x,
  input  logic [$clog2(IMG_H)-1:0] y,
  output logic [ADDR_W-1:0]        addr,
  output logic                     oob
);

  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_q;

  // Product formed at 64 bits, then truncated: out-of-range coords wrap modulo 2**ADDR_W.
  assign addr_d = ADDR_W'(64'(BASE_ADDR) +
                          64'(BYTES_PER_PIXEL) * (64'(y) * 64'(IMG_W) + 64'(x)));

`ifdef PIXEL_FETCH_BOUNDS_CHECK_EN
  assign oob = (32'(x) >= IMG_W) || (32'(y) >= IMG_H);
`else
  assign oob = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (en) begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/pixel_fetch.sv
// Fetches one 24-bit RGB pixel as three byte reads from a 1-cycle-latency memory.
// Define PIXEL_FETCH_BOUNDS_CHECK_EN to answer out-of-range coordinates with pix_err instead.
module pixel_fetch
  import pixel_pkg::*;
#(
  parameter int unsigned IMG_W     = 900,
  parameter int unsigned IMG_H     = 300,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [$clog2(IMG_W)-1:0] req_x,
  input  logic [$clog2(IMG_H)-1:0] req_y,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [7:0]               mem_rd_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [23:0]              pix_data,
  output logic                     pix_err
);

  if (64'(BASE_ADDR) + 64'(BYTES_PER_PIXEL) * 64'(IMG_W) * 64'(IMG_H) > (64'd1 << ADDR_W))
  begin : g_size_check
    $error("pixel_fetch: frame does not fit in the ADDR_W-bit byte address space");
  end

  fetch_state_t             state_q, state_d;
  logic [1:0]               k_q, k_d;
  logic [$clog2(IMG_W)-1:0] x_q, x_d;
  logic [$clog2(IMG_H)-1:0] y_q, y_d;
  rgb_t                     pix_q, pix_d;
  logic                     err_q, err_d;
  logic [ADDR_W-1:0]        addr_q;
  logic                     oob;

  pixel_addr_calc #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_addr_calc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == CALC),
    .x    (x_q),
    .y    (y_q),
    .addr (addr_q),
    .oob  (oob)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    y_d     = y_q;
    pix_d   = pix_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          x_d     = req_x;
          y_d     = req_y;
          state_d = CALC;
        end
      end
      CALC: begin
        k_d   = '0;
        err_d = oob;
        if (oob) begin
          pix_d   = '0;
          state_d = OUT;
        end else begin
          state_d = READ;
        end
      end
      READ: begin
        // Read data trails its strobe by one cycle: byte k lands while strobe k+1 is out.
        if (k_q == 2'd1) pix_d.r = mem_rd_data;
        if (k_q == 2'd2) begin
          pix_d.g = mem_rd_data;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      DRAIN: begin
        pix_d.b = mem_rd_data;
        state_d = OUT;
      end
      OUT: begin
        if (pix_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pix_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pix_q   <= pix_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mem_rd_en = (state_q == READ);
  assign mem_addr  = (state_q == READ) ? addr_q + ADDR_W'(k_q) : '0;
  assign pix_valid = (state_q == OUT);
  assign pix_data  = pix_q;
  assign pix_err   = (state_q == OUT) & err_q;

endmodule

// File: tb/tb_pixel_fetch.sv
// Bench for pixel_fetch: two instances (BASE_ADDR 0 and 100) share the request and pixel
// handshakes; expectations come from an arithmetic model of address, memory and pixel.
module tb_pixel_fetch;

  localparam int unsigned IMG_W  = 900;
  localparam int unsigned IMG_H  = 300;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned BASE_B = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [9:0]  req_x = '0;
  logic [8:0]  req_y = '0;
  logic        pix_ready = 1'b0;

  logic        a_req_ready, a_mem_rd_en, a_pix_valid, a_pix_err;
  logic [19:0] a_mem_addr;
  logic [7:0]  a_mem_rd_data = '0;
  logic [23:0] a_pix_data;
  logic        b_req_ready, b_mem_rd_en, b_pix_valid, b_pix_err;
  logic [19:0] b_mem_addr;
  logic [7:0]  b_mem_rd_data = '0;
  logic [23:0] b_pix_data;

  int n_pass = 0;
  int n_tot  = 0;

  pixel_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .BASE_ADDR(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_x(req_x), .req_y(req_y), .mem_rd_en(a_mem_rd_en), .mem_addr(a_mem_addr),
    .mem_rd_data(a_mem_rd_data), .pix_valid(a_pix_valid), .pix_ready(pix_ready),
    .pix_data(a_pix_data), .pix_err(a_pix_err)
  );

  pixel_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_x(req_x), .req_y(req_y), .mem_rd_en(b_mem_rd_en), .mem_addr(b_mem_addr),
    .mem_rd_data(b_mem_rd_data), .pix_valid(b_pix_valid), .pix_ready(pix_ready),
    .pix_data(b_pix_data), .pix_err(b_pix_err)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed hash of the address, with 11/22/33 planted at 2706..2708.
  function automatic logic [7:0] mem_byte(input logic [19:0] a);
    logic [31:0] t;
    case (a)
      20'd2706: return 8'h11;
      20'd2707: return 8'h22;
      20'd2708: return 8'h33;
      default: begin
        t = 32'(a) * 32'd37 + 32'(a >> 8) + 32'd5;
        return t[7:0];
      end
    endcase
  endfunction

  always @(posedge clk) begin
    if (a_mem_rd_en) a_mem_rd_data <= mem_byte(a_mem_addr);
    if (b_mem_rd_en) b_mem_rd_data <= mem_byte(b_mem_addr);
  end

  function automatic logic [19:0] model_addr(input int unsigned base, input int unsigned x,
                                             input int unsigned y);
    longint unsigned a;
    a = longint'(base) + 64'd3 * (longint'(y) * IMG_W + longint'(x));
    return a[19:0];
  endfunction

  function automatic logic model_oob(input int unsigned x, input int unsigned y);
`ifdef PIXEL_FETCH_BOUNDS_CHECK_EN
    return (x >= IMG_W) || (y >= IMG_H);
`else
    return (x + y) > 32'hffff_fff0;
`endif
  endfunction

  function automatic logic [23:0] model_pix(input int unsigned base, input int unsigned x,
                                            input int unsigned y);
    logic [19:0] a;
    if (model_oob(x, y)) return 24'h0;
    a = model_addr(base, x, y);
    return {mem_byte(a), mem_byte(a + 20'd1), mem_byte(a + 20'd2)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Precondition: called #1 after an edge with both DUTs idle.
  task automatic run_req(input logic [9:0] x, input logic [8:0] y, input int stall,
                         input logic [19:0] ea, input logic [19:0] eb,
                         input logic [23:0] pa, input logic [23:0] pb, input logic err);
    int vcyc;
    pix_ready = 1'b0;
    req_x = x;
    req_y = y;
    req_valid = 1'b1;
    chk("req_ready_idle", a_req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_x = 10'($urandom);
    req_y = 9'($urandom);
    chk("calc_no_rd", a_mem_rd_en, 0);
    chk("calc_busy", a_req_ready, 0);
    vcyc = err ? 1 : 5;
    for (int c = 1; c < vcyc; c++) begin
      @(posedge clk); #1;
      chk("rd_en_a", a_mem_rd_en, (c <= 3) ? 1 : 0);
      chk("rd_en_b", b_mem_rd_en, (c <= 3) ? 1 : 0);
      if (c <= 3) begin
        chk("addr_a", a_mem_addr, ea + 20'(c - 1));
        chk("addr_b", b_mem_addr, eb + 20'(c - 1));
      end
      chk("valid_early", a_pix_valid, 0);
      chk("busy", a_req_ready, 0);
    end
    @(posedge clk); #1;
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", a_pix_valid, 1);
      chk("stall_data", a_pix_data, pa);
      chk("stall_no_rd", a_mem_rd_en, 0);
      chk("stall_busy", a_req_ready, 0);
      @(posedge clk); #1;
    end
    chk("pix_valid_a", a_pix_valid, 1);
    chk("pix_valid_b", b_pix_valid, 1);
    chk("pix_data_a", a_pix_data, pa);
    chk("pix_data_b", b_pix_data, pb);
    chk("pix_err_a", a_pix_err, err);
    chk("pix_err_b", b_pix_err, err);
    pix_ready = 1'b1;
    @(posedge clk); #1;
    pix_ready = 1'b0;
    chk("after_xfer_valid", a_pix_valid, 0);
    chk("after_xfer_ready", a_req_ready, 1);
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [8:0]  y;
    int          stall;
    logic [19:0] addr_a;
    logic [19:0] addr_b;
    logic [23:0] pix_a;
    logic        err;
  } vec_t;

  vec_t        vecs[4];
  logic [23:0] sb_q[$];

  initial begin
    logic [9:0]  rx;
    logic [8:0]  ry;
    logic [23:0] exp_pix;

    vecs[0] = '{x: 10'd2, y: 9'd1, stall: 0, addr_a: 20'd2706, addr_b: 20'd2806,
                pix_a: 24'h112233, err: 1'b0};
    vecs[1] = '{x: 10'd0, y: 9'd0, stall: 10, addr_a: 20'd0, addr_b: 20'd100,
                pix_a: model_pix(0, 0, 0), err: 1'b0};
    vecs[2] = '{x: 10'd899, y: 9'd299, stall: 2, addr_a: 20'd809997, addr_b: 20'd810097,
                pix_a: model_pix(0, 899, 299), err: 1'b0};
`ifdef PIXEL_FETCH_BOUNDS_CHECK_EN
    vecs[3] = '{x: 10'd900, y: 9'd0, stall: 1, addr_a: 20'd0, addr_b: 20'd0,
                pix_a: 24'h0, err: 1'b1};
`else
    vecs[3] = '{x: 10'd900, y: 9'd0, stall: 1, addr_a: 20'd2700, addr_b: 20'd2800,
                pix_a: model_pix(0, 900, 0), err: 1'b0};
`endif

    // Reset values
    #1;
    chk("rst_req_ready", a_req_ready, 1);
    chk("rst_rd_en", a_mem_rd_en, 0);
    chk("rst_addr", a_mem_addr, 0);
    chk("rst_valid", a_pix_valid, 0);
    chk("rst_data", a_pix_data, 0);
    chk("rst_err", a_pix_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_req(vecs[i].x, vecs[i].y, vecs[i].stall, vecs[i].addr_a, vecs[i].addr_b,
              vecs[i].pix_a, model_pix(BASE_B, vecs[i].x, vecs[i].y), vecs[i].err);
    end

    // Reset while the second byte strobe is out abandons the request.
    req_x = 10'd5;
    req_y = 9'd5;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_k1_addr", a_mem_addr, model_addr(0, 5, 5) + 20'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_en", a_mem_rd_en, 0);
    chk("midrst_valid", a_pix_valid, 0);
    chk("midrst_ready", a_req_ready, 1);
    chk("midrst_data", a_pix_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_valid", a_pix_valid, 0);
    run_req(10'd7, 9'd3, 1, model_addr(0, 7, 3), model_addr(BASE_B, 7, 3),
            model_pix(0, 7, 3), model_pix(BASE_B, 7, 3), model_oob(7, 3));

    // Random requests, occasionally out of range (wrap or error depending on build).
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rx = 10'($urandom);
        ry = 9'($urandom_range(300, 511));
      end else begin
        rx = 10'($urandom_range(0, IMG_W - 1));
        ry = 9'($urandom_range(0, IMG_H - 1));
      end
      run_req(rx, ry, $urandom_range(0, 3), model_addr(0, rx, ry), model_addr(BASE_B, rx, ry),
              model_pix(0, rx, ry), model_pix(BASE_B, rx, ry), model_oob(rx, ry));
    end

    // Back-to-back with req_valid held high; pixels must come out in request order.
    pix_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx = 10'($urandom_range(0, IMG_W - 1));
      ry = 9'($urandom_range(0, IMG_H - 1));
      req_x = rx;
      req_y = ry;
      chk("b2b_ready", a_req_ready, 1);
      sb_q.push_back(model_pix(0, rx, ry));
      @(posedge clk); #1;
      req_x = 10'($urandom);
      req_y = 9'($urandom);
      repeat (5) begin
        @(posedge clk); #1;
      end
      chk("b2b_valid", a_pix_valid, 1);
      exp_pix = sb_q.pop_front();
      chk("b2b_order", a_pix_data, exp_pix);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    pix_ready = 1'b0;
    @(posedge clk); #1;
    chk("b2b_final_idle", a_req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
